// File: rtl/imem_loader.sv
// Boot-time program loader: parses a word-count header from a byte stream and writes
// little-endian 32-bit words to instruction memory. Optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << (ADDR_W - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       k_q, k_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       shift_q, shift_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;

    // rx_ready_q mirrors the state, so a transfer is exactly what the source sees handshaked.
    assign xfer = rx_valid & rx_ready_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR0;
                    error_d = 1'b0;
                    k_d     = 16'd0;
                    bcnt_d  = 2'd0;
                    shift_d = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    n_d[7:0] = rx_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    n_d[15:8] = rx_data;
                    if ({1'b0, rx_data, n_q[7:0]} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if ({rx_data, n_q[7:0]} == 16'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = {rx_data, shift_q[23:8]};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {rx_data, shift_q};
                        mem_addr_d  = {k_q[ADDR_W-3:0], 2'b00};
                        k_d         = k_q + 16'd1;
                        if (k_q + 16'd1 == n_q) begin
                            state_d = S_FINISH;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) begin
            error_d = 1'b1;
        end

        // Status outputs are registered from the next state so they line up with it.
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_d == S_CHK)
`endif
                     ;
        cpu_hold_d = busy_d | error_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= 16'd0;
            k_q         <= 16'd0;
            bcnt_q      <= 2'd0;
            shift_q     <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected writes come from a word-level model
// of the stream, checked by a monitor whenever mem_we is seen.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 1 << (ADDR_W - 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim_data[$];
    int         tests    = 0;
    int         fails    = 0;
    int         done_cnt = 0;
    int         cyc      = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every sampled mem_we cycle must match the next expected write, so a
    // stretched strobe or a stray write shows up as an extra pop.
    always @(negedge clk) begin
        wr_t w;
        if (done) done_cnt++;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected", mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                check_output("wr_addr", 32'(mem_addr), 32'(w.addr));
                check_output("wr_data", mem_wdata, w.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        forever begin
            ok = rx_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 50) begin
                tests++;
                fails++;
                $display("[TB] FAIL ready_timeout: rx_ready 0 for 50 cycles, expected 1");
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim_data.delete();
        for (int i = 0; i < 4 * n; i++) stim_data.push_back(8'($urandom));
    endtask

    // One complete session from start to the cycle after DONE/ERR; the model derives
    // the writes and outcome from the header and data bytes alone.
    task automatic run_session(input int n, input int max_gap, input bit bad_chk,
                               input bit hold_start, input bit timing_chk);
        bit          ok;
        bit          legal;
        logic [7:0]  csum;
        logic [15:0] n16;
        int          s;
        int          d0;
        int          exp_lat;
        wr_t         w;
        n16   = 16'(n);
        legal = (n <= MAX_WORDS);
        ok    = legal && !bad_chk;
        csum  = 8'h00;
        if (legal) begin
            for (int k = 0; k < n; k++) begin
                w.addr = 8'(4 * k);
                w.data = {stim_data[4*k+3], stim_data[4*k+2], stim_data[4*k+1], stim_data[4*k]};
                exp_q.push_back(w);
            end
            for (int i = 0; i < 4 * n; i++) csum = csum ^ stim_data[i];
        end
        exp_lat = legal ? 2 + 4 * n + CHK_BYTES : 2;
        d0 = done_cnt;

        start = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc;
        start = hold_start;
        send_byte(n16[7:0], max_gap);
        send_byte(n16[15:8], max_gap);
        if (legal) begin
            for (int i = 0; i < 4 * n; i++) send_byte(stim_data[i], max_gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (csum ^ 8'h01) : csum, max_gap);
`endif
        end
        start = 1'b0;

        if (timing_chk) check_output("latency", 32'(cyc - s), 32'(exp_lat));
        check_output("done_in_final", 32'(done), 32'(ok));
        check_output("hold_in_final", 32'(cpu_hold), 32'd1);
        check_output("we_in_final", 32'(mem_we), 32'(legal && n > 0 && CHK_BYTES == 0));
        @(posedge clk);
        #1;
        check_output("done_after", 32'(done), 32'd0);
        check_output("busy_after", 32'(busy), 32'd0);
        check_output("error_after", 32'(error), 32'(!ok));
        check_output("hold_after", 32'(cpu_hold), 32'(!ok));
        check_output("ready_after", 32'(rx_ready), 32'd0);
        check_output("pending_writes", 32'(exp_q.size()), 32'd0);
        check_output("done_pulses", 32'(done_cnt - d0), 32'(ok));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ready", 32'(rx_ready), 32'd0);
        check_output("rst_we", 32'(mem_we), 32'd0);
        check_output("rst_addr", 32'(mem_addr), 32'd0);
        check_output("rst_wdata", mem_wdata, 32'd0);
        check_output("rst_hold", 32'(cpu_hold), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Bytes offered while idle must not be consumed.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) begin
            check_output("idle_ready", 32'(rx_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;

        stim_data = '{8'h93, 8'h80, 8'h70, 8'h00, 8'h13, 8'h01, 8'h31, 8'h00};
        run_session(2, 0, 1'b0, 1'b0, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_session(2, 0, 1'b1, 1'b0, 1'b1);
        run_session(2, 0, 1'b0, 1'b0, 1'b1);
`endif

        stim_data.delete();
        run_session(0, 0, 1'b0, 1'b0, 1'b1);
        run_session(65, 0, 1'b0, 1'b0, 1'b1);

        fill_random(MAX_WORDS);
        run_session(MAX_WORDS, 0, 1'b0, 1'b1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(6, 1));
            fill_random(n);
            run_session(n, 5, 1'b0, 1'($urandom_range(1, 0)), 1'b0);
        end

        // Reset after five data bytes: only word 0 reaches memory.
        begin
            wr_t w;
            fill_random(2);
            w.addr = 8'h00;
            w.data = {stim_data[3], stim_data[2], stim_data[1], stim_data[0]};
            exp_q.push_back(w);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            send_byte(8'h02, 0);
            send_byte(8'h00, 0);
            for (int i = 0; i < 5; i++) send_byte(stim_data[i], 2);
            reset = 1'b1;
            @(posedge clk);
            #1;
            check_output("mid_rst_ready", 32'(rx_ready), 32'd0);
            check_output("mid_rst_we", 32'(mem_we), 32'd0);
            check_output("mid_rst_addr", 32'(mem_addr), 32'd0);
            check_output("mid_rst_wdata", mem_wdata, 32'd0);
            check_output("mid_rst_hold", 32'(cpu_hold), 32'd0);
            check_output("mid_rst_busy", 32'(busy), 32'd0);
            check_output("mid_rst_done", 32'(done), 32'd0);
            check_output("mid_rst_error", 32'(error), 32'd0);
            check_output("mid_rst_pending", 32'(exp_q.size()), 32'd0);
            reset = 1'b0;
            @(posedge clk);
            #1;
            fill_random(2);
            run_session(2, 3, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
